// File: rtl/mext_issue_unit_pkg.sv
// Shared types for the M-extension issue path: multiplier operation encoding.
package mext_issue_unit_pkg;

  typedef enum logic [2:0] {
    MUL_NONE = 3'd0,
    MUL      = 3'd1,
    MULH     = 3'd2,
    MULHSU   = 3'd3,
    MULHU    = 3'd4
  } riscv_mul_op_e;

endpackage

// File: rtl/mext_issue_unit.sv
// RV32M issue unit: decodes a multiply request, hands operands to the iterative
// multiplier, collects its result and returns it to writeback tagged with rd.
module mext_issue_unit
  import mext_issue_unit_pkg::*;
#(
  parameter bit          ZERO_BYPASS = 1'b1,
  parameter int unsigned RD_W        = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [31:0]     req_rs1,
  input  logic [31:0]     req_rs2,
  input  logic [RD_W-1:0] req_rd,
  output logic            mul_valid,
  input  logic            mul_ready,
  output logic [31:0]     mul_a,
  output logic [31:0]     mul_b,
  output riscv_mul_op_e   mul_op,
  input  logic            rsp_valid,
  output logic            rsp_ready,
  input  logic [31:0]     rsp_data,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [RD_W-1:0] wb_rd,
  output logic [31:0]     wb_data,
  output logic            wb_err,
  output logic            busy
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              err_q, err_d;
  riscv_mul_op_e     op_q, op_d;
  logic              accept;

  function automatic riscv_mul_op_e decode_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return MUL;
      3'b001:  return MULH;
      3'b010:  return MULHSU;
      3'b011:  return MULHU;
      default: return MUL_NONE;
    endcase
  endfunction

  // State and payload registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
      op_q    <= MUL_NONE;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
      err_q   <= err_d;
      op_q    <= op_d;
    end
  end

  // Next state, payload updates and handshake outputs; flush outranks everything
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    data_d    = data_q;
    err_d     = err_q;
    op_d      = op_q;
    req_ready = 1'b0;
    mul_valid = 1'b0;
    rsp_ready = 1'b0;
    wb_valid  = 1'b0;
    accept    = 1'b0;

    case (state_q)
      S_IDLE: begin
        req_ready = !rst && !flush;
        accept    = req_valid && req_ready;
        if (accept) begin
          a_d    = req_rs1;
          b_d    = req_rs2;
          rd_d   = req_rd;
          op_d   = decode_op(req_funct3);
          data_d = '0;
          err_d  = 1'b0;
          if (req_funct3[2]) begin
            err_d   = 1'b1;
            state_d = S_WB;
          end else if (ZERO_BYPASS && (req_rs1 == '0 || req_rs2 == '0)) begin
            state_d = S_WB;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        mul_valid = 1'b1;
        // A flush racing an accepted issue must still absorb the multiplier's answer
        if (flush) begin
          state_d = mul_ready ? S_DRAIN : S_IDLE;
        end else if (mul_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        rsp_ready = 1'b1;
        if (flush) begin
          state_d = rsp_valid ? S_IDLE : S_DRAIN;
        end else if (rsp_valid) begin
          data_d  = rsp_data;
          state_d = S_WB;
        end
      end

      S_WB: begin
        wb_valid = 1'b1;
        if (flush || wb_ready) begin
          state_d = S_IDLE;
        end
      end

      S_DRAIN: begin
        rsp_ready = 1'b1;
        if (rsp_valid) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign mul_a   = a_q;
  assign mul_b   = b_q;
  assign mul_op  = op_q;
  assign wb_rd   = rd_q;
  assign wb_data = data_q;
  assign wb_err  = err_q;
  assign busy    = (state_q != S_IDLE);

  // Interface protocol properties
  a_mul_stable : assert property (@(posedge clk) disable iff (rst)
    (mul_valid && !mul_ready) |=> $stable({mul_a, mul_b, mul_op}));

  a_wb_stable : assert property (@(posedge clk) disable iff (rst)
    (wb_valid && !wb_ready) |=> $stable({wb_rd, wb_data, wb_err}));

  a_rsp_state : assert property (@(posedge clk) disable iff (rst)
    (rsp_valid && rsp_ready) |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule

// File: tb/tb_mext_issue_unit.sv
// Scoreboard bench for mext_issue_unit with a behavioural multiplier and writeback sink.
module tb_mext_issue_unit;
  import mext_issue_unit_pkg::*;

  localparam int unsigned RD_W = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = '0;
  logic [31:0]     req_rs1 = '0;
  logic [31:0]     req_rs2 = '0;
  logic [RD_W-1:0] req_rd = '0;
  logic            mul_valid;
  logic            mul_ready = 1'b0;
  logic [31:0]     mul_a;
  logic [31:0]     mul_b;
  riscv_mul_op_e   mul_op;
  logic            rsp_valid = 1'b0;
  logic            rsp_ready;
  logic [31:0]     rsp_data = '0;
  logic            wb_valid;
  logic            wb_ready = 1'b0;
  logic [RD_W-1:0] wb_rd;
  logic [31:0]     wb_data;
  logic            wb_err;
  logic            busy;

  mext_issue_unit #(.ZERO_BYPASS(1'b1), .RD_W(RD_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .mul_valid(mul_valid), .mul_ready(mul_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_op(mul_op), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_err(wb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [RD_W-1:0] rd;
    logic [31:0]     data;
    logic            err;
  } exp_t;

  typedef struct {
    logic [31:0]   a;
    logic [31:0]   b;
    riscv_mul_op_e op;
  } iss_t;

  exp_t exp_q[$];
  iss_t iss_q[$];

  int checks = 0;
  int failures = 0;
  bit bp = 1'b0;
  int lat = 2;
  int wb_hold_cnt = 0;
  int issue_cnt = 0;
  int rsp_cnt = 0;
  int wb_cnt = 0;
  int wb_exp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference product: {err, data} from funct3 and operands
  function automatic logic [32:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    if (f3[2]) return {1'b1, 32'h0};
    case (f3[1:0])
      2'd0:    p = sa * sb;
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f3[1:0] == 2'd0) ? {1'b0, p[31:0]} : {1'b0, p[63:32]};
  endfunction

  function automatic riscv_mul_op_e ref_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return MUL;
      3'd1:    return MULH;
      3'd2:    return MULHSU;
      3'd3:    return MULHU;
      default: return MUL_NONE;
    endcase
  endfunction

  function automatic logic [2:0] op_f3(input riscv_mul_op_e op);
    case (op)
      MUL:     return 3'd0;
      MULH:    return 3'd1;
      MULHSU:  return 3'd2;
      MULHU:   return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  // Behavioural multiplier: drives at negedge, observes handshakes 1 time unit later
  initial begin : mul_model
    bit          m_busy = 1'b0;
    int          m_cnt = 0;
    logic [31:0] m_res = '0;
    logic [32:0] r;
    bit          hold = 1'b0;
    logic [34:0] last_opa = '0;
    logic [31:0] last_b = '0;
    iss_t        e;
    forever begin
      @(negedge clk);
      mul_ready = !m_busy && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (m_busy && m_cnt == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = m_res;
      end else begin
        rsp_valid = 1'b0;
        rsp_data  = $urandom;
        if (m_busy) m_cnt--;
      end
      #1;
      if (hold && mul_valid) begin
        check("mul_opa_stable", 64'({mul_op, mul_a}), 64'(last_opa));
        check("mul_b_stable", 64'(mul_b), 64'(last_b));
      end
      hold     = mul_valid && !mul_ready;
      last_opa = {mul_op, mul_a};
      last_b   = mul_b;
      if (mul_valid && mul_ready) begin
        issue_cnt++;
        if (iss_q.size() == 0) begin
          check("mul_unexpected_issue", 64'(1), 64'(0));
        end else begin
          e = iss_q.pop_front();
          check("mul_a", 64'(mul_a), 64'(e.a));
          check("mul_b", 64'(mul_b), 64'(e.b));
          check("mul_op", 64'(mul_op), 64'(e.op));
        end
        r      = ref_result(op_f3(mul_op), mul_a, mul_b);
        m_res  = r[31:0];
        m_busy = 1'b1;
        m_cnt  = bp ? int'($urandom_range(0, 5)) : lat;
      end
      if (rsp_valid && rsp_ready) begin
        m_busy = 1'b0;
        rsp_cnt++;
      end
    end
  end

  // Writeback sink: pops the scoreboard on each wb handshake
  initial begin : wb_model
    bit          hold = 1'b0;
    logic [37:0] last = '0;
    exp_t        e;
    forever begin
      @(negedge clk);
      wb_ready = (wb_hold_cnt > 0) ? 1'b0 : (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
      #1;
      if (hold && wb_valid) check("wb_stable", 64'({wb_err, wb_rd, wb_data}), 64'(last));
      hold = wb_valid && !wb_ready;
      last = {wb_err, wb_rd, wb_data};
      if (wb_valid && !wb_ready && wb_hold_cnt > 0) wb_hold_cnt--;
      if (wb_valid && wb_ready) begin
        wb_cnt++;
        if (exp_q.size() == 0) begin
          check("wb_unexpected", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", 64'(wb_rd), 64'(e.rd));
          check("wb_data", 64'(wb_data), 64'(e.data));
          check("wb_err", 64'(wb_err), 64'(e.err));
        end
      end
    end
  end

  task automatic send(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                      input logic [RD_W-1:0] rd, input logic [32:0] exp_r);
    int   n;
    exp_t e;
    bit   is_mul;
    @(negedge clk);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
    #1;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("accept_timeout", 64'(n < 300), 64'(1));
    if (n >= 300) begin
      req_valid = 1'b0;
      return;
    end
    e.rd   = rd;
    e.data = exp_r[31:0];
    e.err  = exp_r[32];
    exp_q.push_back(e);
    wb_exp++;
    is_mul = !f3[2] && a != 0 && b != 0;
    if (is_mul) iss_q.push_back('{a, b, ref_op(f3)});
    @(negedge clk);
    req_valid  = 1'b0;
    req_funct3 = 3'($urandom);
    req_rs1    = $urandom;
    req_rs2    = $urandom;
    #1;
    check("post_accept_lat", 64'({busy, mul_valid, wb_valid}),
          is_mul ? 64'(3'b110) : 64'(3'b101));
  endtask

  task automatic wait_wb(input int target);
    int n;
    n = 0;
    while (wb_cnt < target && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("wb_timeout", 64'(wb_cnt >= target), 64'(1));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          ic, rc, wc, n;
    logic [31:0] a, b;
    logic [2:0]  f3;

    repeat (3) @(negedge clk);
    #1;
    check("reset_outs", 64'({req_ready, mul_valid, rsp_ready, wb_valid, wb_err, busy}), 64'(0));
    check("reset_wb_payload", 64'({wb_rd, wb_data}), 64'(0));
    check("reset_mul_op", 64'(mul_op), 64'(MUL_NONE));
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("idle_ready", 64'({req_ready, busy}), 64'(2'b10));

    // Flush in idle suppresses the accept
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd1; req_rs2 = 32'd1;
    #1;
    check("flush_idle_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    #1;
    check("flush_idle_busy", 64'(busy), 64'(0));

    // Directed multiplies
    send(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, {1'b0, 32'hFFFFFFEB});
    wait_wb(wb_exp);
    send(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, {1'b0, 32'hFFFFFFFE});
    wait_wb(wb_exp);
    send(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, {1'b0, 32'h00000000});
    wait_wb(wb_exp);
    send(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, {1'b0, 32'hFFFFFFFF});
    wait_wb(wb_exp);
    send(3'd0, 32'd3, 32'd4, 5'd0, {1'b0, 32'd12});
    wait_wb(wb_exp);

    // Zero bypass and divide rejection never reach the multiplier
    ic = issue_cnt;
    send(3'd0, 32'h1234, 32'h0, 5'd7, {1'b0, 32'h0});
    wait_wb(wb_exp);
    send(3'd4, 32'd100, 32'd7, 5'd9, {1'b1, 32'h0});
    wait_wb(wb_exp);
    check("no_issue_bypass_err", 64'(issue_cnt), 64'(ic));

    // Flush while waiting on a slow multiply, then the next request after the drain
    lat = 35;
    ic = issue_cnt; rc = rsp_cnt; wc = wb_cnt;
    send(3'd0, 32'd3, 32'd5, 5'd3, {1'b0, 32'd15});
    n = 0;
    while (issue_cnt == ic && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("flush_issue_seen", 64'(issue_cnt), 64'(ic + 1));
    check("wait_rsp_ready", 64'({busy, rsp_ready, wb_valid}), 64'(3'b110));
    @(negedge clk);
    flush = 1'b1;
    #1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("drain_state", 64'({busy, wb_valid, rsp_ready, req_ready}), 64'(4'b1010));
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    wb_exp--;
    lat = 2;
    send(3'd1, 32'h80000000, 32'd2, 5'd4, {1'b0, 32'hFFFFFFFF});
    check("drain_before_accept", 64'(rsp_cnt), 64'(rc + 1));
    wait_wb(wb_exp);
    check("flush_no_wb", 64'(wb_cnt), 64'(wc + 1));

    // Writeback held off for 10 cycles under random backpressure
    bp = 1'b1;
    wb_hold_cnt = 10;
    send(3'd3, 32'hDEADBEEF, 32'h10, 5'd2, {1'b0, 32'h0000000D});
    wait_wb(wb_exp);
    check("hold_consumed", 64'(wb_hold_cnt), 64'(0));

    // Random traffic with backpressure on both sides
    for (int i = 0; i < 25; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      send(f3, a, b, 5'($urandom), ref_result(f3, a, b));
      wait_wb(wb_exp);
    end

    bp = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check("wb_count", 64'(wb_cnt), 64'(wb_exp));
    check("sb_empty", 64'(exp_q.size()), 64'(0));
    check("iss_empty", 64'(iss_q.size()), 64'(0));
    check("final_idle", 64'({busy, req_ready}), 64'(2'b01));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
